// File: rtl/imu_reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// imu_reset_sequencer_if
//
// Purpose: bundles the sensor-side and status signals of the multi-sensor
// BNO085 power-up sequencer so the sequencer and its neighbours can connect
// through a single port.
//
// Signals:
//   start        request to re-run the full power-up sequence (single cycle)
//   int_n        raw BNO085 INT pins, active low, asynchronous
//   imu_rst_n    BNO085 hardware reset pins, active low
//   ctrl_rst_n   per-channel reset to bno085_controller + spi_master, active low
//   ready        channel booted and released
//   timeout_err  channel failed to boot
//   busy         sequence in progress
//   cur_ch       channel currently being sequenced
//
// Modports:
//   master  the sequencer (drives resets and status)
//   slave   the board / requester side (drives start, returns int_n)
// -----------------------------------------------------------------------------
interface imu_reset_sequencer_if #(
    parameter int NUM_SENSORS = 2
);
    localparam int CH_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

    logic                   start;
    logic [NUM_SENSORS-1:0] int_n;
    logic [NUM_SENSORS-1:0] imu_rst_n;
    logic [NUM_SENSORS-1:0] ctrl_rst_n;
    logic [NUM_SENSORS-1:0] ready;
    logic [NUM_SENSORS-1:0] timeout_err;
    logic                   busy;
    logic [CH_W-1:0]        cur_ch;

    modport master (
        input  start,
        input  int_n,
        output imu_rst_n,
        output ctrl_rst_n,
        output ready,
        output timeout_err,
        output busy,
        output cur_ch
    );

    modport slave (
        output start,
        output int_n,
        input  imu_rst_n,
        input  ctrl_rst_n,
        input  ready,
        input  timeout_err,
        input  busy,
        input  cur_ch
    );
endinterface

// File: rtl/imu_reset_sequencer.sv
// -----------------------------------------------------------------------------
// imu_reset_sequencer
//
// Purpose: powers up NUM_SENSORS BNO085 sensors one at a time in ascending
// channel order. For each channel it pulses the sensor hardware reset, waits
// (bounded) for the sensor to pull INT low, waits a settle delay and only then
// releases the matching controller/SPI-master reset. A channel whose sensor
// never signals boot is flagged in timeout_err and left with its controller
// held in reset; the sequence then moves on to the next channel.
//
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    imu_reset_sequencer_if.master (start, int_n in; imu_rst_n,
//          ctrl_rst_n, ready, timeout_err, busy, cur_ch out)
//
// Build option:
//   IMU_RST_RETRY_EN  when defined, a timed-out channel is re-pulsed up to
//                     MAX_RETRY more times before timeout_err is raised.
//                     When undefined the first timeout is final and no retry
//                     counter exists.
// -----------------------------------------------------------------------------
module imu_reset_sequencer #(
    parameter int NUM_SENSORS    = 2,
    parameter int HOLD_CYCLES    = 300,
    parameter int TIMEOUT_CYCLES = 600000,
    parameter int SETTLE_CYCLES  = 6000000,
    parameter int MAX_RETRY      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    imu_reset_sequencer_if.master  bus
);

    localparam int CH_W     = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam int MAX_HT   = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CNT  = (MAX_HT > SETTLE_CYCLES) ? MAX_HT : SETTLE_CYCLES;
    localparam int CNT_W    = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(NUM_SENSORS - 1);

    // Reject unsupported channel counts or a negative retry budget at elaboration.
    if (NUM_SENSORS < 1 || NUM_SENSORS > 8 || MAX_RETRY < 0) begin : g_bad_params
        $error("imu_reset_sequencer: NUM_SENSORS must be 1..8 and MAX_RETRY >= 0");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ASSERT    = 3'd1,
        S_WAIT_BOOT = 3'd2,
        S_SETTLE    = 3'd3,
        S_RELEASE   = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                 state_r,       state_s;
    logic [CNT_W-1:0]       cnt_r,         cnt_s;
    logic [CH_W-1:0]        cur_ch_r,      cur_ch_s;
    logic [CH_W-1:0]        next_ch_s;
    logic [NUM_SENSORS-1:0] imu_rst_n_r,   imu_rst_n_s;
    logic [NUM_SENSORS-1:0] ctrl_rst_n_r,  ctrl_rst_n_s;
    logic [NUM_SENSORS-1:0] ready_r,       ready_s;
    logic [NUM_SENSORS-1:0] timeout_err_r, timeout_err_s;
    logic                   busy_r,        busy_s;
    logic                   advance_s;
    logic                   counting_s;
    logic [NUM_SENSORS-1:0] int_meta_r;
    logic [NUM_SENSORS-1:0] int_sync_r;

`ifdef IMU_RST_RETRY_EN
    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RT_W-1:0] RETRY_LIMIT = RT_W'(MAX_RETRY);
    logic [RT_W-1:0]        retry_r,       retry_s;
`endif

    // Two-flop synchroniser for the asynchronous INT pins; idles deasserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int_meta_r <= {NUM_SENSORS{1'b1}};
            int_sync_r <= {NUM_SENSORS{1'b1}};
        end else begin
            int_meta_r <= bus.int_n;
            int_sync_r <= int_meta_r;
        end
    end

    // Next state, shared counter and next values of every registered output.
    always_comb begin
        state_s       = state_r;
        cur_ch_s      = cur_ch_r;
        next_ch_s     = cur_ch_r + CH_W'(1);
        imu_rst_n_s   = imu_rst_n_r;
        ctrl_rst_n_s  = ctrl_rst_n_r;
        ready_s       = ready_r;
        timeout_err_s = timeout_err_r;
        busy_s        = busy_r;
        advance_s     = 1'b0;
        counting_s    = 1'b0;
        cnt_s         = cnt_r;
`ifdef IMU_RST_RETRY_EN
        retry_s       = retry_r;
`endif

        case (state_r)
            S_IDLE: begin
                // Resets are already asserted from rst_n; start channel 0.
                state_s  = S_ASSERT;
                cur_ch_s = {CH_W{1'b0}};
                busy_s   = 1'b1;
            end

            S_ASSERT: begin
                counting_s = 1'b1;
                if (cnt_r == HOLD_LAST) begin
                    state_s               = S_WAIT_BOOT;
                    imu_rst_n_s[cur_ch_r] = 1'b1;
                end else begin
                    state_s = S_ASSERT;
                end
            end

            S_WAIT_BOOT: begin
                counting_s = 1'b1;
                // INT is tested first so it wins over a same-cycle timeout.
                if (!int_sync_r[cur_ch_r]) begin
                    state_s = S_SETTLE;
                end else if (cnt_r == TIMEOUT_LAST) begin
`ifdef IMU_RST_RETRY_EN
                    if (retry_r < RETRY_LIMIT) begin
                        retry_s               = retry_r + RT_W'(1);
                        state_s               = S_ASSERT;
                        imu_rst_n_s[cur_ch_r] = 1'b0;
                    end else begin
                        timeout_err_s[cur_ch_r] = 1'b1;
                        advance_s               = 1'b1;
                    end
`else
                    timeout_err_s[cur_ch_r] = 1'b1;
                    advance_s               = 1'b1;
`endif
                end else begin
                    state_s = S_WAIT_BOOT;
                end
            end

            S_SETTLE: begin
                counting_s = 1'b1;
                if (cnt_r == SETTLE_LAST) begin
                    state_s = S_RELEASE;
                end else begin
                    state_s = S_SETTLE;
                end
            end

            S_RELEASE: begin
                ctrl_rst_n_s[cur_ch_r] = 1'b1;
                ready_s[cur_ch_r]      = 1'b1;
                advance_s              = 1'b1;
            end

            S_DONE: begin
                if (bus.start) begin
                    state_s       = S_ASSERT;
                    cur_ch_s      = {CH_W{1'b0}};
                    imu_rst_n_s   = {NUM_SENSORS{1'b0}};
                    ctrl_rst_n_s  = {NUM_SENSORS{1'b0}};
                    ready_s       = {NUM_SENSORS{1'b0}};
                    timeout_err_s = {NUM_SENSORS{1'b0}};
                    busy_s        = 1'b1;
`ifdef IMU_RST_RETRY_EN
                    retry_s       = {RT_W{1'b0}};
`endif
                end else begin
                    state_s = S_DONE;
                end
            end

            default: begin
                state_s = S_IDLE;
            end
        endcase

        // Move on after a release or a final timeout; last channel ends the run.
        if (advance_s) begin
`ifdef IMU_RST_RETRY_EN
            retry_s = {RT_W{1'b0}};
`endif
            if (cur_ch_r == LAST_CH) begin
                state_s = S_DONE;
                busy_s  = 1'b0;
            end else begin
                state_s                = S_ASSERT;
                cur_ch_s               = next_ch_s;
                imu_rst_n_s[next_ch_s] = 1'b0;
            end
        end else begin
            state_s = state_s;
        end

        // One shared counter, cleared whenever a state is (re-)entered.
        if (state_s != state_r) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (counting_s) begin
            cnt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            cur_ch_r      <= {CH_W{1'b0}};
            imu_rst_n_r   <= {NUM_SENSORS{1'b0}};
            ctrl_rst_n_r  <= {NUM_SENSORS{1'b0}};
            ready_r       <= {NUM_SENSORS{1'b0}};
            timeout_err_r <= {NUM_SENSORS{1'b0}};
            busy_r        <= 1'b0;
`ifdef IMU_RST_RETRY_EN
            retry_r       <= {RT_W{1'b0}};
`endif
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            cur_ch_r      <= cur_ch_s;
            imu_rst_n_r   <= imu_rst_n_s;
            ctrl_rst_n_r  <= ctrl_rst_n_s;
            ready_r       <= ready_s;
            timeout_err_r <= timeout_err_s;
            busy_r        <= busy_s;
`ifdef IMU_RST_RETRY_EN
            retry_r       <= retry_s;
`endif
        end
    end

    assign bus.imu_rst_n   = imu_rst_n_r;
    assign bus.ctrl_rst_n  = ctrl_rst_n_r;
    assign bus.ready       = ready_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.busy        = busy_r;
    assign bus.cur_ch      = cur_ch_r;

endmodule

// File: doc/imu_reset_sequencer.md
# imu_reset_sequencer

Parametrised multi-sensor BNO085 power-up sequencer that replaces the single-sensor, button-driven two-stage reset logic in the sensor top levels. It drives each sensor's hardware reset, waits for the sensor's INT boot indication with a timeout, applies a settle delay, and only then releases the matching bno085_controller/spi_master reset. It sits between the board reset and the per-sensor SPI stacks in drum_set_top.

## Interface
- NUM_SENSORS, 2, number of sensor channels (1..8)
- HOLD_CYCLES, 300, imu_rst_n low pulse width per channel (100 µs at 3 MHz)
- TIMEOUT_CYCLES, 600000, maximum wait for int_n low after reset release
- SETTLE_CYCLES, 6000000, delay from INT detection to controller release
- MAX_RETRY, 2, reset retries per channel after a timeout (retry build only)

- clk  in  1  system clock (3 MHz HSOSC)
- rst_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to re-run the full sequence
- int_n  in  NUM_SENSORS  raw BNO085 INT pins, active low, asynchronous
- imu_rst_n  out  NUM_SENSORS  BNO085 hardware reset pins, active low
- ctrl_rst_n  out  NUM_SENSORS  per-channel reset to controller + SPI master, active low
- ready  out  NUM_SENSORS  channel booted and released
- timeout_err  out  NUM_SENSORS  channel failed to boot
- busy  out  1  sequence in progress
- cur_ch  out  $clog2(NUM_SENSORS) or 1  channel currently being sequenced

## Operation
- int_n passes through a 2-flop synchroniser per channel; all decisions use the synchronised value.
- Channels sequenced strictly one at a time, ascending index; the sensors are never released simultaneously.
- States: IDLE, ASSERT, WAIT_BOOT, SETTLE, RELEASE, DONE.
- IDLE: entered from reset; moves to ASSERT with cur_ch=0 on the next cycle (automatic start).
- ASSERT: imu_rst_n[cur_ch]=0 for exactly HOLD_CYCLES cycles, then WAIT_BOOT.
- WAIT_BOOT: imu_rst_n[cur_ch]=1; the counter runs. Synchronised int_n[cur_ch]==0 -> SETTLE. The counter reaching TIMEOUT_CYCLES-1 without INT is a timeout (see Configuration).
- SETTLE: counts SETTLE_CYCLES, then RELEASE.
- RELEASE (1 cycle): ctrl_rst_n[cur_ch] and ready[cur_ch] are set. Then cur_ch+1 -> ASSERT, or DONE if cur_ch==NUM_SENSORS-1.
- Failed channel: timeout_err set, ctrl_rst_n kept 0, imu_rst_n left 1, and the sequence advances to the next channel as from RELEASE.
- DONE: busy=0; outputs hold. start in DONE -> all imu_rst_n, ctrl_rst_n, ready, timeout_err cleared to 0 the next cycle; enter ASSERT with cur_ch=0.
- start while busy is ignored.
- Single shared counter, width $clog2(max(HOLD,TIMEOUT,SETTLE)+1); it clears on every state entry.

## Timing
- Reset values (rst_n=0 sampled at a clk edge): imu_rst_n=all 0, ctrl_rst_n=all 0, ready=0, timeout_err=0, busy=0, cur_ch=0, state IDLE, retry count 0.
- busy=1 from the first ASSERT cycle until DONE is entered.
- INT detection latency: 2 cycles for the synchroniser plus 1 cycle for the state transition.
- Channel k release: ctrl_rst_n[k] rises exactly SETTLE_CYCLES+1 cycles after the WAIT_BOOT->SETTLE transition.
- An INT pulse that arrives during ASSERT is ignored; only WAIT_BOOT samples it.
- If INT and the timeout occur in the same cycle, INT wins and the channel goes to SETTLE.
- rst_n low mid-sequence: all outputs return to reset values on that edge, and the sequence restarts from channel 0 after release.
- A released ctrl_rst_n is never dropped except by rst_n or start-in-DONE.

## Configuration
- IMU_RST_RETRY_EN defined: on a timeout with retries_used < MAX_RETRY, the block increments retries_used and returns to ASSERT for the same channel, with no error flag. A timeout with retries_used == MAX_RETRY sets timeout_err. The retry count resets on each channel advance.
- IMU_RST_RETRY_EN undefined: the first timeout sets timeout_err immediately. MAX_RETRY is unused and no retry counter is built.

## Test plan
Parameters for all cases: NUM_SENSORS=2, HOLD=4, TIMEOUT=20, SETTLE=8.
- Nominal: rst_n released and int_n[0] pulled low 5 cycles into WAIT_BOOT, then the same for ch1 -> imu_rst_n[0] low exactly 4 cycles, ctrl_rst_n[0] rises 9 cycles after SETTLE entry, ch1 follows, ready=2'b11, busy falls, timeout_err=0.
- Timeout (no retry build): int_n[1] held high -> timeout_err=2'b10, ctrl_rst_n=2'b01, DONE reached 20 cycles after ch1 WAIT_BOOT entry.
- Retry (IMU_RST_RETRY_EN, MAX_RETRY=2): int_n[0] low only on the 2nd reset pulse -> two ASSERT windows on ch0, ready[0]=1, timeout_err[0]=0; never low -> 3 pulses, then timeout_err[0]=1.
- Restart: start pulse in DONE -> next cycle all outputs 0, busy=1, cur_ch=0; start pulse while busy -> no effect on state or counters.
- Mid-sequence reset: rst_n low during SETTLE of ch1 -> outputs at reset values on that edge; sequence restarts at ch0 after release.
- INT and timeout coincident: int_n[0] synchronised low on cycle 19 of WAIT_BOOT -> SETTLE entered, no timeout_err.
